// File: rtl/mul_issue_queue.sv
// mul_issue_queue: operand FIFO and issue sequencer for a sequential
// shift-add multiplier. Operand pairs are queued, issued one job at a time
// with a single-cycle mul_run pulse, and each 64-bit product is returned in
// order through a one-entry result register on a valid/ready port.
// Optional build macro: MUL_SIGNED_EN (two's-complement operands; magnitudes
// are issued and the product sign is restored on capture).
module mul_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_mcand,
    input  logic [31:0]              in_mplier,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [63:0]              res_product,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     mul_run,
    output logic [31:0]              mul_mcand,
    output logic [31:0]              mul_mplier,
    input  logic                     mul_ready,
    input  logic [63:0]              mul_product
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_CAPTURE
    } state_t;

    // Storage and FIFO bookkeeping
    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_in_ready;

    // Sequencer and output registers
    state_t        r_state;
    logic          r_guard;
    logic          r_mul_run;
    logic [31:0]   r_mcand;
    logic [31:0]   r_mplier;
    logic          r_res_valid;
    logic [63:0]   r_res_product;

    logic          w_push;
    logic          w_pop;
    logic          w_drain;
    logic [CW-1:0] w_count_nxt;
    logic [63:0]   w_head;
    logic [31:0]   w_head_mcand;
    logic [31:0]   w_head_mplier;
    logic [31:0]   w_op_mcand;
    logic [31:0]   w_op_mplier;
    logic [63:0]   w_cap_product;

    assign w_push        = in_valid && r_in_ready;
    assign w_pop         = (r_state == S_IDLE) && (r_count != '0) && mul_ready;
    assign w_drain       = r_res_valid && res_ready;
    assign w_count_nxt   = r_count + CW'(w_push) - CW'(w_pop);
    assign w_head        = r_mem[r_rptr];
    assign w_head_mcand  = w_head[63:32];
    assign w_head_mplier = w_head[31:0];

`ifdef MUL_SIGNED_EN
    logic r_neg;
    logic w_neg;

    // Magnitudes go to the unsigned multiplier; the sign is reapplied on capture.
    assign w_op_mcand    = w_head_mcand[31]  ? -w_head_mcand  : w_head_mcand;
    assign w_op_mplier   = w_head_mplier[31] ? -w_head_mplier : w_head_mplier;
    assign w_neg         = w_head_mcand[31] ^ w_head_mplier[31];
    assign w_cap_product = r_neg ? -mul_product : mul_product;
`else
    assign w_op_mcand    = w_head_mcand;
    assign w_op_mplier   = w_head_mplier;
    assign w_cap_product = mul_product;
`endif

    // FIFO payload write; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {in_mcand, in_mplier};
        end
    end

    // FIFO pointers, occupancy and registered in_ready (held low through reset)
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt < CW'(DEPTH));
        end
    end

    // Issue FSM with registered multiplier controls and the result register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_guard       <= 1'b0;
            r_mul_run     <= 1'b0;
            r_mcand       <= '0;
            r_mplier      <= '0;
            r_res_valid   <= 1'b0;
            r_res_product <= '0;
`ifdef MUL_SIGNED_EN
            r_neg         <= 1'b0;
`endif
        end else begin
            r_mul_run <= 1'b0;
            // A capture below overrides this clear, so drain+capture keeps valid high.
            if (w_drain) begin
                r_res_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_mcand   <= w_op_mcand;
                        r_mplier  <= w_op_mplier;
`ifdef MUL_SIGNED_EN
                        r_neg     <= w_neg;
`endif
                        r_mul_run <= 1'b1;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    r_guard <= 1'b1;
                    r_state <= S_BUSY;
                end
                S_BUSY: begin
                    // First BUSY cycle may still see the multiplier's stale ready.
                    if (r_guard) begin
                        r_guard <= 1'b0;
                    end else if (mul_ready) begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (!r_res_valid || res_ready) begin
                        r_res_product <= w_cap_product;
                        r_res_valid   <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign res_valid   = r_res_valid;
    assign res_product = r_res_product;
    assign fifo_count  = r_count;
    assign mul_run     = r_mul_run;
    assign mul_mcand   = r_mcand;
    assign mul_mplier  = r_mplier;

endmodule

// File: tb/tb_mul_issue_queue.sv
// Testbench for mul_issue_queue: behavioural multiplier, in-order result
// scoreboard, table-driven vectors, hand-written corner sequences and a
// randomized traffic phase.
module tb_mul_issue_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int LAT   = 8;
    localparam int NV    = 5;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_mcand;
    logic [31:0]   in_mplier;
    logic          res_valid;
    logic          res_ready;
    logic [63:0]   res_product;
    logic [CW-1:0] fifo_count;
    logic          mul_run;
    logic [31:0]   mul_mcand;
    logic [31:0]   mul_mplier;
    logic          mul_ready = 1'b1;
    logic [63:0]   mul_product = '0;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_q[$];
    logic        last_push;
    logic        prev_run = 1'b0;
    logic        seen_run;
    logic        saw_full;
    int          runs;
    int          drained;

    vec_t vecs [NV];

    always #5 clk = ~clk;

    mul_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mcand    (in_mcand),
        .in_mplier   (in_mplier),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_product (res_product),
        .fifo_count  (fifo_count),
        .mul_run     (mul_run),
        .mul_mcand   (mul_mcand),
        .mul_mplier  (mul_mplier),
        .mul_ready   (mul_ready),
        .mul_product (mul_product)
    );

    // Behavioural unsigned multiplier: accepts run while idle, drops ready,
    // and presents the product LAT cycles later, holding it while idle.
    logic        m_busy = 1'b0;
    int          m_cnt  = 0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    always @(posedge clk) begin
        if (!rst) begin
            m_busy      <= 1'b0;
            m_cnt       <= 0;
            mul_ready   <= 1'b1;
            mul_product <= '0;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_busy      <= 1'b0;
                mul_ready   <= 1'b1;
                mul_product <= {32'b0, m_a} * {32'b0, m_b};
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (mul_run) begin
            m_a       <= mul_mcand;
            m_b       <= mul_mplier;
            m_busy    <= 1'b1;
            m_cnt     <= LAT;
            mul_ready <= 1'b0;
        end
    end

    // Reference product from plain arithmetic on the operand values.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa;
        logic [63:0] xb;
`ifdef MUL_SIGNED_EN
        xa = {{32{a[31]}}, a};
        xb = {{32{b[31]}}, b};
`else
        xa = {32'b0, a};
        xb = {32'b0, b};
`endif
        return xa * xb;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: condition not reached within its cycle budget", name);
    endtask

    // One clock: observe handshakes at the falling edge, then return 1 time unit
    // after the next rising edge so the caller can drive new inputs.
    task automatic cyc();
        logic [63:0] e;
        @(negedge clk);
        last_push = 1'b0;
        if (!rst) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_mul(in_mcand, in_mplier));
                last_push = 1'b1;
            end
            if (res_valid && res_ready) begin
                drained++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL result_unexpected: got %h expected no result", res_product);
                end else begin
                    e = exp_q.pop_front();
                    check("result_order", res_product, e);
                end
            end
            if (mul_run) begin
                runs++;
                seen_run = 1'b1;
                check("run_single_cycle", 64'(prev_run), 64'd0);
            end
        end
        prev_run = mul_run;
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
        int n;
        in_mcand  = a;
        in_mplier = b;
        in_valid  = 1'b1;
        n = 0;
        last_push = 1'b0;
        while (!last_push && n < 200) begin
            cyc();
            n++;
            if (fifo_count == CW'(DEPTH)) begin
                saw_full = 1'b1;
                check("full_blocks_in_ready", 64'(in_ready), 64'd0);
            end
        end
        in_valid = 1'b0;
        if (!last_push) fail_now("push_timeout");
    endtask

    task automatic wait_result(input string name);
        int n;
        n = 0;
        while (!res_valid && n < 100) begin
            cyc();
            n++;
        end
        if (!res_valid) fail_now(name);
    endtask

    task automatic drain_all(input string name);
        int n;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || fifo_count != '0 || res_valid) && n < 2000) begin
            cyc();
            n++;
        end
        if (n >= 2000) fail_now(name);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        saw;

`ifdef MUL_SIGNED_EN
        vecs[0] = '{32'hFFFF_FFFD, 32'd5,        64'hFFFF_FFFF_FFFF_FFF1};
        vecs[1] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[2] = '{32'd0,         32'hFFFF_FFF9, 64'h0};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1};
        vecs[4] = '{32'd3,         32'd5,        64'hF};
`else
        vecs[0] = '{32'd3,         32'd5,        64'hF};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'd0,         32'h1234_5678, 64'h0};
        vecs[3] = '{32'd1,         32'hDEAD_BEEF, 64'h0000_0000_DEAD_BEEF};
        vecs[4] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
`endif

        rst = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        in_mcand = '0; in_mplier = '0;
        runs = 0; drained = 0; seen_run = 1'b0; saw_full = 1'b0;

        // Reset state
        repeat (3) cyc();
        check("rst_in_ready",    64'(in_ready),    64'd0);
        check("rst_res_valid",   64'(res_valid),   64'd0);
        check("rst_res_product", res_product,      64'd0);
        check("rst_fifo_count",  64'(fifo_count),  64'd0);
        check("rst_mul_run",     64'(mul_run),     64'd0);
        check("rst_mul_mcand",   64'(mul_mcand),   64'd0);
        check("rst_mul_mplier",  64'(mul_mplier),  64'd0);
        rst = 1'b1;
        cyc();
        check("release_in_ready", 64'(in_ready), 64'd1);

        // Table-driven single jobs
        for (int i = 0; i < NV; i++) begin
            runs = 0;
            push_pair(vecs[i].a, vecs[i].b);
            wait_result("vec_result_timeout");
            check("vec_product", res_product, vecs[i].exp);
            if (i == 0) check("vec0_run_pulses", 64'(runs), 64'd1);
            res_ready = 1'b1;
            cyc();
            res_ready = 1'b0;
            check("vec_fifo_empty", 64'(fifo_count), 64'd0);
            check("vec_res_cleared", 64'(res_valid), 64'd0);
        end

        // Backpressure: six jobs with the consumer stalled
        res_ready = 1'b0;
        saw_full  = 1'b0;
        for (int k = 0; k < 6; k++) push_pair($urandom, $urandom);
        repeat (3 * LAT) cyc();
        runs = 0;
        repeat (2 * LAT) cyc();
        check("bp_saw_full",    64'(saw_full),   64'd1);
        check("bp_fifo_full",   64'(fifo_count), 64'(DEPTH));
        check("bp_in_ready",    64'(in_ready),   64'd0);
        check("bp_res_valid",   64'(res_valid),  64'd1);
        check("bp_stalled",     64'(runs),       64'd0);
        drained = 0;
        drain_all("bp_drain_timeout");
        check("bp_all_results", 64'(drained),    64'd6);
        res_ready = 1'b0;

        // Reset while a job is in the multiplier, with one more queued
        seen_run = 1'b0;
        push_pair(32'd11, 32'd13);
        push_pair(32'd17, 32'd19);
        begin
            int n;
            n = 0;
            while (!seen_run && n < 50) begin
                cyc();
                n++;
            end
            if (!seen_run) fail_now("busy_reach_timeout");
        end
        rst = 1'b0;
        cyc();
        check("mid_rst_res_valid",  64'(res_valid),  64'd0);
        check("mid_rst_res_prod",   res_product,     64'd0);
        check("mid_rst_fifo_count", 64'(fifo_count), 64'd0);
        check("mid_rst_mul_run",    64'(mul_run),    64'd0);
        check("mid_rst_mcand",      64'(mul_mcand),  64'd0);
        check("mid_rst_mplier",     64'(mul_mplier), 64'd0);
        check("mid_rst_in_ready",   64'(in_ready),   64'd0);
        rst = 1'b1;
        res_ready = 1'b1;
        saw = 1'b0;
        repeat (4 * LAT) begin
            cyc();
            if (res_valid) saw = 1'b1;
        end
        check("mid_rst_no_spurious", 64'(saw), 64'd0);
        res_ready = 1'b0;
        push_pair(32'd7, 32'd6);
        wait_result("post_rst_timeout");
        check("post_rst_product", res_product, ref_mul(32'd7, 32'd6));
        drain_all("post_rst_drain_timeout");
        res_ready = 1'b0;

        // Concurrent push, drain and capture; then push alongside a pop
        push_pair(32'd21, 32'd2);
        push_pair(32'd100, 32'd3);
        push_pair(32'd9, 32'd9);
        repeat (4 * LAT) cyc();
        check("cc_pre_count",   64'(fifo_count), 64'd1);
        check("cc_pre_valid",   64'(res_valid),  64'd1);
        check("cc_pre_product", res_product,     ref_mul(32'd21, 32'd2));
        in_mcand = 32'd4; in_mplier = 32'd8; in_valid = 1'b1; res_ready = 1'b1;
        cyc();
        check("cc_push_taken",   64'(last_push),  64'd1);
        check("cc_valid_kept",   64'(res_valid),  64'd1);
        check("cc_new_product",  res_product,     ref_mul(32'd100, 32'd3));
        check("cc_count_push",   64'(fifo_count), 64'd2);
        in_mcand = 32'd5; in_mplier = 32'd10; res_ready = 1'b0;
        cyc();
        in_valid = 1'b0;
        check("cc_push_pop_push", 64'(last_push),  64'd1);
        check("cc_count_const",   64'(fifo_count), 64'd2);
        check("cc_run_started",   64'(mul_run),    64'd1);
        drain_all("cc_drain_timeout");

        // Randomized traffic against the scoreboard
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 7))
                0:       ra = 32'hFFFF_FFFF;
                1:       ra = 32'h8000_0000;
                2:       ra = 32'd0;
                default: ra = $urandom;
            endcase
            rb = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            in_mcand  = ra;
            in_mplier = rb;
            in_valid  = ($urandom_range(0, 2) != 0);
            res_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        drain_all("rand_drain_timeout");
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        check("final_fifo_empty",  64'(fifo_count),   64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_issue_queue.md
# mul_issue_queue

Operand queue and issue sequencer sitting directly upstream of the sequential shift-add multiplier. Buffers operand pairs from the datapath, drives the multiplier's `run`/operand inputs one job at a time, and captures each 64-bit product when the multiplier reports `ready`. Returns results in order on a valid/ready result port.

## Interface
- `DEPTH`, 4: operand FIFO entries; power of two, 2..16.
- `clk`  in  1  rising-edge clock, shared with the multiplier.
- `rst`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  FIFO can accept; transfer when `in_valid && in_ready`.
- `in_mcand`  in  32  multiplicand.
- `in_mplier`  in  32  multiplier.
- `res_valid`  out  1  `res_product` holds a result.
- `res_ready`  in  1  consumer accepts; transfer when `res_valid && res_ready`.
- `res_product`  out  64  product.
- `fifo_count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `mul_run`  out  1  one-cycle start pulse to the multiplier.
- `mul_mcand`  out  32  to multiplier `Multiplicand`.
- `mul_mplier`  out  32  to multiplier `Multiplier`.
- `mul_ready`  in  1  from multiplier `ready`.
- `mul_product`  in  64  from multiplier `Product`.

## Operation
- FIFO: circular, `DEPTH` entries, 64 bits each (mcand, mplier); wrap-around read/write pointers plus a count. `in_ready` = count < DEPTH. Simultaneous push and pop when full is not allowed (push blocked by `in_ready`); simultaneous push and pop when not full leaves the count unchanged.
- FSM states:
  - IDLE: if the FIFO is non-empty and `mul_ready`=1, pop the head into the operand registers and go to START.
  - START: `mul_run`=1 for this cycle only; go to BUSY.
  - BUSY: ignore `mul_ready` in the first BUSY cycle (guard). Afterwards, when `mul_ready`=1, go to CAPTURE.
  - CAPTURE: if the result register is empty, or is being drained this cycle, load `mul_product`, set `res_valid`, and go to IDLE. Otherwise stay in CAPTURE (stall); the multiplier holds `Product` while idle.
- `mul_mcand`/`mul_mplier` are registered and held stable from START until the next pop.
- Result register: one entry. Cleared on a `res_valid && res_ready` handshake. A capture in the same cycle as a drain leaves `res_valid`=1 with the new value.
- Results leave in the same order the operands entered.
- The multiplier's own reset is active-high. The top level drives it with `~rst`, so both blocks reset together.

## Timing
- Reset (`rst`=0 at a clock edge) clears:
  - state to IDLE and pointers/count to 0;
  - `in_ready`=0 during reset, then 1 on the first cycle after release;
  - `res_valid`=0, `res_product`=0, `fifo_count`=0, `mul_run`=0;
  - `mul_mcand`=0, `mul_mplier`=0.
- Reset mid-operation: queued and in-flight jobs are discarded, with no spurious `res_valid`.
- Latency from push to pop: 1 cycle minimum (an entry pushed in cycle t is poppable in t+1).
- Total latency: push → START ≥2 cycles; START → `res_valid` = multiplier latency + 2 cycles (guard + CAPTURE).
- Back-to-back jobs: at most one multiplier job per multiplier latency + 4 cycles.
- `mul_run` is never asserted in two consecutive cycles, and never outside START.

## Configuration
- `MUL_SIGNED_EN` defined: operands are two's-complement.
  - On pop, the absolute values are sent to the multiplier and the sign XOR is recorded.
  - On capture, the 64-bit product is negated when the sign XOR is 1.
  - Edge case: -2^31 × -2^31 = 0x4000000000000000.
- `MUL_SIGNED_EN` undefined: operands pass through unsigned; the sign logic is absent.

## Test plan
- Reset, then push (3, 5) → `mul_run` pulses once; `res_valid` rises with `res_product`=0x000000000000000F; `fifo_count` returns to 0.
- Push (0xFFFFFFFF, 0xFFFFFFFF), unsigned build → `res_product`=0xFFFFFFFE00000001.
- Hold `res_ready`=0 and push 6 pairs (DEPTH=4):
  - `in_ready` drops when `fifo_count`=4, and the FSM stalls in CAPTURE.
  - Release `res_ready` → all results arrive in order and none are lost.
- Assert `rst`=0 while in BUSY → all outputs return to reset values next cycle; `res_valid` stays 0 after release until a new push completes.
- With `MUL_SIGNED_EN`:
  - (-3, 5) → 0xFFFFFFFFFFFFFFF1.
  - (-2^31, -2^31) → 0x4000000000000000.
  - (0, -7) → 0.
- Push and drain in the same cycle while the FIFO and result are both non-empty → `fifo_count` stays constant, and `res_valid` remains 1 with the new value.
